// File: rtl/barrier_ctrl_pkg.sv
// Shared definitions for the barrier controller: FSM state encoding and
// the supported range of participating processes.
package barrier_pkg;

  localparam int NPROC_MIN = 2;
  localparam int NPROC_MAX = 8;

  typedef logic [1:0] bstate_t;

  localparam bstate_t B_IDLE    = 2'd0;
  localparam bstate_t B_GATHER  = 2'd1;
  localparam bstate_t B_RELEASE = 2'd2;
  localparam bstate_t B_DRAIN   = 2'd3;

endpackage

// File: rtl/barrier_ctrl_rr_arbiter.sv
// Round-robin picker: grants the first requester at or after ptr_i,
// wrapping to index 0 when nothing at or above the pointer is requesting.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  logic [31:0] ptr_ext;
  assign ptr_ext = 32'(ptr_i);

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[i] && (32'(i) >= ptr_ext)) begin
        gnt_o[i] = 1'b1;
        valid_o  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[i] && (32'(i) < ptr_ext)) begin
        gnt_o[i] = 1'b1;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/barrier_ctrl.sv
// Barrier controller: registers one arriving process per cycle (round-robin),
// releases all of them together once every process has arrived.
//   state     | meaning
//   B_IDLE    | no episode open, waiting for any arrival
//   B_GATHER  | registering arrivals, one grant per unpaused cycle
//   B_RELEASE | one-cycle release pulse to all registered processes
//   B_DRAIN   | waiting for every arrive line to drop before re-arming
module barrier_ctrl
  import barrier_pkg::*;
#(
  parameter int NPROC = 4,
  parameter int CW    = $clog2(NPROC + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [NPROC-1:0] arrive_i,
  input  logic             pause_i,
  output logic [NPROC-1:0] grant_o,
  output logic [NPROC-1:0] release_o,
  output logic [CW-1:0]    count_o,
  output logic             sense_o,
  output logic             busy_o,
  output logic             protocol_err_o
);

  localparam int PW = $clog2(NPROC);

  bstate_t          state_q, state_d;
  logic [NPROC-1:0] mask_q, mask_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             sense_q, sense_d;
  logic             err_q, err_d;

  logic [NPROC-1:0] arb_gnt;
  logic             arb_valid;
  logic             gnt_en;
  logic             fire;
  logic [PW-1:0]    ptr_nxt;

  rr_arbiter #(.N(NPROC), .PW(PW)) u_arb (
    .req_i   (arrive_i & ~mask_q),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  assign gnt_en    = (state_q == B_GATHER) && !pause_i;
  assign fire      = gnt_en && arb_valid;
  assign grant_o   = gnt_en ? arb_gnt : '0;
  assign release_o = (state_q == B_RELEASE) ? mask_q : '0;
  assign count_o   = count_q;
  assign sense_o   = sense_q;
  assign busy_o    = (state_q != B_IDLE);
  assign protocol_err_o = err_q;

  always_comb begin
    ptr_nxt = ptr_q;
    for (int i = 0; i < NPROC; i++) begin
      if (arb_gnt[i]) ptr_nxt = (i == NPROC - 1) ? '0 : PW'(i + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    sense_d = sense_q;
    err_d   = err_q;
    case (state_q)
      B_IDLE: begin
        if (|arrive_i) state_d = B_GATHER;
      end
      B_GATHER: begin
        // registration stays sticky even if the requester drops early
        if (|(mask_q & ~arrive_i)) err_d = 1'b1;
        if (fire) begin
          mask_d  = mask_q | arb_gnt;
          count_d = count_q + CW'(1);
          ptr_d   = ptr_nxt;
          if (count_q == CW'(NPROC - 1)) state_d = B_RELEASE;
        end
      end
      B_RELEASE: begin
        mask_d  = '0;
        count_d = '0;
        sense_d = ~sense_q;
        state_d = B_DRAIN;
      end
      default: begin
        if (arrive_i == '0) state_d = B_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= B_IDLE;
      mask_q  <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      sense_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      sense_q <= sense_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/barrier_ctrl.md
BARRIER_CTRL -- requirements
Module: barrier_ctrl

Interface
REQ-001 Parameter NPROC, default 4, number of participating processes, legal range 2..8.
REQ-002 Parameter CW, default $clog2(NPROC+1), width of the arrival counter.
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 arrive  input  NPROC  per-process barrier request: level, held high from arrival until release is seen.
REQ-006 pause  input  1  when 1, no grant is issued that cycle; all other state holds.
REQ-007 grant  output  NPROC  one-hot or zero registration pulse; marks the process whose arrival is counted this cycle.
REQ-008 release  output  NPROC  one-cycle pulse to every registered process when the barrier opens.
REQ-009 count  output  CW  number of processes registered in the current episode.
REQ-010 sense  output  1  episode phase bit; toggles on each release.
REQ-011 busy  output  1  high whenever the state is not B_IDLE.
REQ-012 protocol_err  output  1  sticky flag for a requester protocol violation.

Function
REQ-013 The FSM SHALL have exactly four states: B_IDLE, B_GATHER, B_RELEASE, B_DRAIN.
REQ-014 In B_IDLE, count=0 and mask=0; any arrive bit high SHALL move the FSM to B_GATHER next cycle, with no grant in the B_IDLE cycle.
REQ-015 In B_GATHER with pause=0, the block SHALL select one process i, round-robin, with arrive[i]=1 and mask[i]=0.
- For that process it SHALL drive grant[i]=1 combinationally that cycle.
- On the clock edge it SHALL set mask[i] and increment count.
REQ-016 Round-robin SHALL start the search at pointer p and wrap modulo NPROC; after a grant to i, p becomes (i+1) mod NPROC; p is unchanged when nothing is granted.
REQ-017 At most one grant SHALL be issued per cycle, and none while pause=1 or in any state other than B_GATHER.
REQ-018 The grant that makes count reach NPROC SHALL move the FSM to B_RELEASE on the same edge.
- Latency: the release pulse appears exactly one cycle after the last grant.
REQ-019 In B_RELEASE, release SHALL equal the all-ones mask for one cycle.
- On exit: count clears to 0, mask clears, sense toggles, FSM goes to B_DRAIN.
REQ-020 In B_DRAIN, the FSM SHALL return to B_IDLE in the first cycle in which arrive is all zero.
- Arrivals are not registered while in B_DRAIN.
REQ-021 If arrive[i] falls while mask[i]=1 in B_GATHER, registration SHALL remain sticky and protocol_err SHALL set.
- protocol_err clears only on reset.
REQ-022 pause during B_RELEASE or B_DRAIN SHALL have no effect.
REQ-023 count SHALL never exceed NPROC and SHALL never wrap.

Reset
REQ-024 On rst_n=0, the following SHALL take their reset values immediately, independent of clock:
- FSM=B_IDLE, count=0, mask=0, p=0, sense=0, protocol_err=0.
- release=0, grant=0, busy=0.
REQ-025 Reset asserted mid-episode SHALL discard all registrations and issue no release.
REQ-026 After rst_n rises, the first grant SHALL occur no earlier than the second posedge.

Structure
REQ-027 Package barrier_pkg SHALL hold the state typedef (B_IDLE..B_DRAIN) and the NPROC limit constants.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter, with:
- inputs req and ptr;
- outputs one-hot gnt and a valid flag.

Verification (NPROC=4)
REQ-029 Sequential arrivals:
- arrive raised at 0001, then 0011, then 0111, then 1111, with pause=0.
- Required: grants 0001, 0010, 0100, 1000 in successive B_GATHER cycles.
- Required: release=1111 one cycle after the fourth grant, then sense=1 and count=0.
REQ-030 Simultaneous arrivals:
- arrive=1111 in a single cycle.
- Required: grants follow order 0,1,2,3 from p=0, with count 1,2,3,4.
- Required: the second episode starts its grant order at p=0 again (after 3 wraps to 0).
REQ-031 Pause:
- Hold pause=1 for 3 cycles after the second grant.
- Required: no grants and count=2 throughout the pause; the third grant comes on the first cycle with pause=0.
REQ-032 Protocol violation:
- Drop arrive[1] after it is granted.
- Required: protocol_err=1, count unchanged, and release still 1111 after the remaining grants.
REQ-033 Reset mid-episode:
- Assert rst_n=0 at count=3.
- Required: count, busy, sense and mask are all 0 at once, and no release pulse appears.
REQ-034 Drain:
- Keep arrive[2]=1 for 2 cycles after release.
- Required: the FSM stays in B_DRAIN with no grant until arrive=0000, then returns to B_IDLE.
